rip_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues word fetches on an in-order, variable-latency instruction-memory port.
- Buffers returned words in a small FIFO and presents one instruction per cycle to decode as inst_code with the de_ready strobe.
- Handles redirects (branch, jump, trap, MRET) from execute by flushing buffered and in-flight fetches.

---
 rtl/rip_fetch.sv | 175 +++++++++++++++++
 tb/tb_rip_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rip_fetch.sv
// Instruction-fetch stage: credit-limited fetch issue, in-order response FIFO, redirect flush.
// Build macro RIP_FETCH_ALIGN_CHECK_EN enables halt on misaligned redirect targets.
module rip_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        de_ready,
    output logic [31:0] inst_code,
    output logic [31:0] if_pc,
    output logic        fetch_misaligned
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [31:0]   NOP      = 32'h0000_0013;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);
    localparam logic [0:0]    ST_RUN   = 1'b0;
`ifdef RIP_FETCH_ALIGN_CHECK_EN
    localparam logic [0:0]    ST_HALT  = 1'b1;
`endif

    logic [31:0]   r_pc;
    logic [0:0]    r_state;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_pcq_wr;
    logic [PW-1:0] r_pcq_rd;
    logic          r_misaligned;
    logic [31:0]   r_last_pc;
    logic [31:0]   r_fifo_data [DEPTH];
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_pcq       [DEPTH];

    logic [31:0]   w_redirect_pc;
    logic          w_mis_redir;
    logic [CW:0]   w_credits;
    logic          w_req;
    logic          w_issue;
    logic          w_rsp;
    logic          w_rsp_drop;
    logic          w_rsp_live;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [31:0]   w_pc_d;
    logic [0:0]    w_state_d;
    logic [CW-1:0] w_out_d;
    logic [CW-1:0] w_drop_d;
    logic [CW-1:0] w_count_d;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_ONE;
    endfunction

`ifdef RIP_FETCH_ALIGN_CHECK_EN
    assign w_redirect_pc = redirect_pc;
    assign w_mis_redir   = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign w_redirect_pc = redirect_pc & ~32'h0000_0003;
    assign w_mis_redir   = 1'b0;
`endif

    // Buffered words plus in-flight fetches (including ones to be dropped) bound new issues.
    assign w_credits  = {1'b0, r_count} + {1'b0, r_out};
    assign w_req      = !rst && (r_state == ST_RUN) && !redirect_valid && (w_credits < CREDITS);
    assign w_issue    = w_req && imem_gnt;
    assign w_rsp      = imem_rvalid && (r_out != '0);
    assign w_rsp_drop = w_rsp && (r_drop != '0);
    assign w_rsp_live = w_rsp && (r_drop == '0);
    assign w_push     = w_rsp_live && !redirect_valid;
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && !ex_stall && !redirect_valid;

    always_comb begin
        w_pc_d    = r_pc;
        w_state_d = r_state;
        w_out_d   = r_out;
        w_drop_d  = r_drop;
        w_count_d = r_count;
        if (w_issue) begin
            w_out_d = w_out_d + CNT_ONE;
            w_pc_d  = r_pc + 32'd4;
        end
        if (w_rsp) begin
            w_out_d = w_out_d - CNT_ONE;
        end
        if (redirect_valid) begin
            // A response landing in the redirect cycle belongs to the old path.
            w_pc_d    = w_redirect_pc;
            w_drop_d  = w_rsp ? (r_out - CNT_ONE) : r_out;
            w_count_d = '0;
`ifdef RIP_FETCH_ALIGN_CHECK_EN
            w_state_d = w_mis_redir ? ST_HALT : ST_RUN;
`endif
        end else begin
            if (w_rsp_drop) begin
                w_drop_d = r_drop - CNT_ONE;
            end
            if (w_push && !w_pop) begin
                w_count_d = r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                w_count_d = r_count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_state      <= ST_RUN;
            r_out        <= '0;
            r_drop       <= '0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pcq_wr     <= '0;
            r_pcq_rd     <= '0;
            r_misaligned <= 1'b0;
            r_last_pc    <= RESET_PC;
        end else begin
            r_pc         <= w_pc_d;
            r_state      <= w_state_d;
            r_out        <= w_out_d;
            r_drop       <= w_drop_d;
            r_count      <= w_count_d;
            r_misaligned <= w_mis_redir;
            r_last_pc    <= if_pc;
            if (redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_pcq_wr <= '0;
                r_pcq_rd <= '0;
            end else begin
                if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
                if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
                if (w_issue) r_pcq_wr <= f_inc(r_pcq_wr);
                if (w_rsp_live) r_pcq_rd <= f_inc(r_pcq_rd);
            end
        end
    end

    // Storage arrays need no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_pcq[r_pcq_rd];
        end
        if (w_issue) begin
            r_pcq[r_pcq_wr] <= r_pc;
        end
    end

    assign imem_req         = w_req;
    assign imem_addr        = r_pc;
    assign de_ready         = w_pop;
    assign inst_code        = w_empty ? NOP : r_fifo_data[r_rd_ptr];
    assign if_pc            = w_empty ? r_last_pc : r_fifo_pc[r_rd_ptr];
    assign fetch_misaligned = r_misaligned;

endmodule

// File: tb/tb_rip_fetch.sv
// Self-checking bench for rip_fetch: startup vector table, directed corner sequences and a
// randomized run against a stream-level reference model with a latency-randomized memory.
module tb_rip_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        de_ready;
    logic [31:0] inst_code;
    logic [31:0] if_pc;
    logic        fetch_misaligned;

    rip_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_stall         (ex_stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .de_ready         (de_ready),
        .inst_code        (inst_code),
        .if_pc            (if_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } rsp_t;

    typedef struct {
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          req;
        logic [31:0] addr;
        bit          de;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    rsp_t        memq[$];
    logic [31:0] fetch_log[$];
    vec_t        vecs[7];
    int          cyc, epoch, gnt_pct, lat_min, lat_max, delivered;
    int          errors, checks;
    bit          junk;
    logic [31:0] m_fetch, m_dec, m_last;
    int          m_buf;
    bit          m_halt, m_mis;
    logic        s_req, s_de, s_mis;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] f_word(input logic [31:0] pc);
        return pc ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at the negedge, sample 1 time unit later, advance model, return at negedge.
    task automatic do_cycle(input bit stall, input bit redir, input logic [31:0] rpc);
        bit          gnt, rv, live, exp_req, exp_de;
        logic [31:0] shown;
        rsp_t        r;
        ex_stall       = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        gnt = ($urandom_range(99, 0) < gnt_pct);
        rv  = 1'b0;
        imem_rdata = 32'h0;
        if (junk) begin
            rv = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            rv = 1'b1;
            imem_rdata = f_word(memq[0].addr);
        end
        imem_gnt    = gnt;
        imem_rvalid = rv;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_de = de_ready;
        s_pc = if_pc; s_inst = inst_code; s_mis = fetch_misaligned;

        exp_req = !m_halt && !redir && ((memq.size() + m_buf) < DEPTH);
        exp_de  = (m_buf > 0) && !stall && !redir;
        shown   = (m_buf > 0) ? m_dec : m_last;
        check("imem_req", {31'b0, s_req}, {31'b0, exp_req});
        if (exp_req && s_req) check("imem_addr", s_addr, m_fetch);
        check("de_ready", {31'b0, s_de}, {31'b0, exp_de});
        check("if_pc", s_pc, shown);
        check("inst_code", s_inst, (m_buf > 0) ? f_word(m_dec) : NOP);
        check("fetch_misaligned", {31'b0, s_mis}, {31'b0, m_mis});

        live = 1'b0;
        if (rv && !junk) begin
            live = (memq[0].epoch == epoch) && !redir;
            void'(memq.pop_front());
        end
        if (s_req && gnt) begin
            r.addr  = s_addr;
            r.due   = cyc + 1 + lat_min + $urandom_range(lat_max - lat_min, 0);
            r.epoch = epoch;
            memq.push_back(r);
            fetch_log.push_back(s_addr);
            m_fetch = m_fetch + 32'd4;
        end
        if (s_de) delivered++;
        if (live) m_buf++;
        if (exp_de) begin
            m_buf--;
            m_dec = m_dec + 32'd4;
        end
        m_last = shown;
        m_mis  = 1'b0;
        if (redir) begin
            epoch++;
            m_buf = 0;
`ifdef RIP_FETCH_ALIGN_CHECK_EN
            m_halt  = (rpc[1:0] != 2'b00);
            m_mis   = m_halt;
            m_fetch = rpc;
            m_dec   = rpc;
`else
            m_fetch = rpc & ~32'h3;
            m_dec   = rpc & ~32'h3;
`endif
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ex_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_de_ready", {31'b0, de_ready}, 32'h0);
        check("rst_inst_code", inst_code, NOP);
        check("rst_if_pc", if_pc, RESET_PC);
        check("rst_fetch_misaligned", {31'b0, fetch_misaligned}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        memq.delete();
        epoch++;
        m_buf = 0; m_halt = 1'b0; m_mis = 1'b0;
        m_fetch = RESET_PC; m_dec = RESET_PC; m_last = RESET_PC;
    endtask

    task automatic run_until_de(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            do_cycle(1'b0, 1'b0, 32'h0);
            if (s_de) ok = 1'b1;
        end
    endtask

    task automatic drain();
        gnt_pct = 0;
        for (int i = 0; i < 40 && (memq.size() > 0 || m_buf > 0); i++) do_cycle(1'b0, 1'b0, 32'h0);
        check("drain_idle", 32'(memq.size() + m_buf), 32'h0);
    endtask

    initial begin
        bit          ok;
        int          d0, nreq, npulse, target;
        logic [31:0] wexp[3];
        logic [31:0] rpc;
        errors = 0; checks = 0; cyc = 0; epoch = 0; delivered = 0; junk = 1'b0;
        gnt_pct = 100; lat_min = 0; lat_max = 0;
        vecs[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0, NOP};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4,  1'b0, 32'h0, NOP};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0, f_word(32'h0)};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8,  1'b1, 32'h4, f_word(32'h4)};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hC,  1'b0, 32'h4, NOP};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h8, f_word(32'h8)};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'hC, f_word(32'hC)};

        do_reset();

        // Startup with grant every cycle and one-cycle read latency.
        for (int i = 0; i < 7; i++) begin
            do_cycle(vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            check("vec_req", {31'b0, s_req}, {31'b0, vecs[i].req});
            if (vecs[i].req) check("vec_addr", s_addr, vecs[i].addr);
            check("vec_de", {31'b0, s_de}, {31'b0, vecs[i].de});
            check("vec_pc", s_pc, vecs[i].pc);
            check("vec_inst", s_inst, vecs[i].inst);
        end

        // Stall for 5 cycles: credits fill, then two buffered words drain back to back.
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 32'h0);
        check("stall_req_off", {31'b0, s_req}, 32'h0);
        d0 = delivered;
        do_cycle(1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0);
        check("stall_release", 32'(delivered - d0), 32'h2);

        // Redirect with two fetches in flight.
        drain();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        do_cycle(1'b0, 1'b0, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0);
        check("redir_inflight", 32'(memq.size()), 32'h2);
        do_cycle(1'b0, 1'b1, 32'h100);
        lat_min = 0; lat_max = 0;
        run_until_de(30, ok);
        check("redir_timeout", {31'b0, ok}, 32'h1);
        check("redir_first_pc", s_pc, 32'h100);

        // PC wrap at the top of the address space.
        do_cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        fetch_log.delete();
        for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b0, 32'h0);
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
        check("wrap_count", {31'b0, fetch_log.size() >= 3}, 32'h1);
        for (int i = 0; i < 3; i++) if (i < fetch_log.size()) check("wrap_addr", fetch_log[i], wexp[i]);

        // Misaligned redirect target.
        do_cycle(1'b0, 1'b1, 32'h102);
`ifdef RIP_FETCH_ALIGN_CHECK_EN
        do_cycle(1'b0, 1'b0, 32'h0);
        check("mis_pulse", {31'b0, s_mis}, 32'h1);
        nreq = 0; npulse = 0;
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, 1'b0, 32'h0);
            nreq += int'(s_req);
            npulse += int'(s_mis);
        end
        check("halt_no_req", 32'(nreq), 32'h0);
        check("mis_single", 32'(npulse), 32'h0);
        do_cycle(1'b0, 1'b1, 32'h200);
        run_until_de(30, ok);
        check("resume_timeout", {31'b0, ok}, 32'h1);
        check("resume_pc", s_pc, 32'h200);
`else
        run_until_de(30, ok);
        check("mis_timeout", {31'b0, ok}, 32'h1);
        check("mis_forced_pc", s_pc, 32'h100);
`endif

        // Reset in the middle of traffic; stray responses afterwards are ignored.
        gnt_pct = 100; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 32'h0);
        do_reset();
        junk = 1'b1; gnt_pct = 0;
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b0, 1'b0, 32'h0);
            check("rst_junk_de", {31'b0, s_de}, 32'h0);
            check("rst_junk_req", {31'b0, s_req}, 32'h1);
            check("rst_junk_addr", s_addr, RESET_PC);
        end
        junk = 1'b0; gnt_pct = 100; lat_min = 0; lat_max = 0;
        run_until_de(20, ok);
        check("rst_resume_timeout", {31'b0, ok}, 32'h1);
        check("rst_resume_pc", s_pc, RESET_PC);
        check("rst_resume_inst", s_inst, f_word(RESET_PC));

        // Randomized grants, latencies, stalls and redirects.
        gnt_pct = 60; lat_min = 0; lat_max = 3;
        target = delivered + 200;
        for (int i = 0; i < 20000 && delivered < target; i++) begin
            rpc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0;
            do_cycle($urandom_range(3, 0) == 0, $urandom_range(39, 0) == 0, rpc);
        end
        check("random_progress", {31'b0, delivered >= target}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
